// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: sequential binary-to-BCD conversion of a 14-bit value
// into a display register, time-multiplexed onto digit select / BCD value / enable.
module fnd_scan_controller #(
    parameter int unsigned SCAN_DIV = 100_000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [13:0] i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic        o_ovf,
    output logic [1:0]  o_digitSelect,
    output logic [3:0]  o_value,
    output logic        o_en
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [13:0] VALUE_MAX = 14'd9999;
    localparam logic [3:0]  ITER_LAST = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  iter_cnt;
    logic [13:0] bin_reg;
    logic [15:0] bcd_reg;
    logic [15:0] bcd_adj;
    logic [15:0] display;
    logic        valid;
    logic        ovf;
    logic [PW-1:0] presc;
    logic [1:0]  sel;

    logic        load_accept;
    logic        last_iter;
    logic        scan_tick;
    logic [13:0] value_clamped;
    logic        nz1;
    logic        nz2;
    logic        nz3;
    logic        digit_shown;

    assign load_accept   = (state == ST_IDLE) && i_load;
    assign last_iter     = (state == ST_SHIFT) && (iter_cnt == ITER_LAST);
    assign scan_tick     = (presc == PRESC_LAST);
    assign value_clamped = (i_value > VALUE_MAX) ? VALUE_MAX : i_value;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (load_accept) state_next = ST_SHIFT;
            ST_SHIFT: if (last_iter)   state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_reg;
        for (int unsigned k = 0; k < 4; k++) begin
            if (bcd_reg[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_reg[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            iter_cnt <= '0;
            ovf      <= 1'b0;
            display  <= '0;
            valid    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_accept) begin
                        bin_reg  <= value_clamped;
                        bcd_reg  <= '0;
                        iter_cnt <= '0;
                        ovf      <= (i_value > VALUE_MAX);
                    end
                end
                ST_SHIFT: begin
                    bcd_reg  <= {bcd_adj[14:0], bin_reg[13]};
                    bin_reg  <= {bin_reg[12:0], 1'b0};
                    iter_cnt <= iter_cnt + 4'd1;
                end
                ST_DONE: begin
                    display <= bcd_reg;
                    valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Scan prescaler and digit select run independently of the conversion.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc <= '0;
            sel   <= '0;
        end else if (scan_tick) begin
            presc <= '0;
            sel   <= sel + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign nz3 = |display[15:12];
    assign nz2 = nz3 | (|display[11:8]);
    assign nz1 = nz2 | (|display[7:4]);

    always_comb begin
        o_value     = '0;
        digit_shown = 1'b1;
        case (sel)
            2'd0: begin o_value = display[3:0];   digit_shown = 1'b1; end
            2'd1: begin o_value = display[7:4];   digit_shown = nz1;  end
            2'd2: begin o_value = display[11:8];  digit_shown = nz2;  end
            2'd3: begin o_value = display[15:12]; digit_shown = nz3;  end
            default: ;
        endcase
    end

    assign o_en          = valid && ((BLANK_LZ == 0) || digit_shown);
    assign o_busy        = (state != ST_IDLE);
    assign o_ovf         = ovf;
    assign o_digitSelect = sel;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: two instances (leading-zero blanking on/off) driven by
// directed and random loads, compared every cycle against a decimal-arithmetic model.
module tb_fnd_scan_controller;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [13:0] i_value;
    logic        i_load;

    logic        busy_b, ovf_b, en_b;
    logic [1:0]  sel_b;
    logic [3:0]  val_b;
    logic        busy_s, ovf_s, en_s;
    logic [1:0]  sel_s;
    logic [3:0]  val_s;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    // model state
    int m_presc = 0;
    int m_sel = 0;
    int m_busy_cnt = 0;
    int m_pend = 0;
    int m_disp = 0;
    bit m_valid = 0;
    bit m_ovf = 0;

    fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) u_dut_blank (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(i_value), .i_load(i_load),
        .o_busy(busy_b), .o_ovf(ovf_b), .o_digitSelect(sel_b), .o_value(val_b), .o_en(en_b)
    );

    fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) u_dut_show (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(i_value), .i_load(i_load),
        .o_busy(busy_s), .o_ovf(ovf_s), .o_digitSelect(sel_s), .o_value(val_s), .o_en(en_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    task automatic model_reset();
        m_presc = 0; m_sel = 0; m_busy_cnt = 0; m_pend = 0;
        m_disp = 0; m_valid = 0; m_ovf = 0;
    endtask

    // One clock edge of the behavioural model: scan counter plus a 15-clock conversion delay.
    always @(posedge clk) begin
        if (rst_n) begin
            if (m_presc == SCAN_DIV - 1) begin
                m_presc = 0;
                m_sel = (m_sel + 1) % 4;
            end else begin
                m_presc++;
            end
            if (m_busy_cnt > 0) begin
                m_busy_cnt--;
                if (m_busy_cnt == 0) begin
                    m_disp = m_pend;
                    m_valid = 1;
                end
            end else if (i_load) begin
                m_pend = (int'(i_value) > 9999) ? 9999 : int'(i_value);
                m_ovf = (int'(i_value) > 9999);
                m_busy_cnt = 15;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            int exp_digit;
            bit exp_en_b;
            exp_digit = (m_disp / pow10(m_sel)) % 10;
            exp_en_b = m_valid && (m_sel == 0 || m_disp >= pow10(m_sel));
            check_eq("busy", 32'(busy_b), 32'(m_busy_cnt > 0));
            check_eq("ovf", 32'(ovf_b), 32'(m_ovf));
            check_eq("sel", 32'(sel_b), 32'(m_sel));
            check_eq("value", 32'(val_b), 32'(exp_digit));
            check_eq("en_blank", 32'(en_b), 32'(exp_en_b));
            check_eq("busy_show", 32'(busy_s), 32'(m_busy_cnt > 0));
            check_eq("sel_show", 32'(sel_s), 32'(m_sel));
            check_eq("value_show", 32'(val_s), 32'(exp_digit));
            check_eq("en_show", 32'(en_s), 32'(m_valid));
        end
    end

    task automatic do_load(input int v);
        @(negedge clk);
        i_value = 14'(v);
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_b), 0);
        check_eq({tag, "_ovf"}, 32'(ovf_b), 0);
        check_eq({tag, "_sel"}, 32'(sel_b), 0);
        check_eq({tag, "_value"}, 32'(val_b), 0);
        check_eq({tag, "_en"}, 32'(en_b), 0);
        check_eq({tag, "_en_show"}, 32'(en_s), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        i_load = 1'b0;
        i_value = '0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1;

        // scan stepping after reset
        wait_neg(4);
        check_eq("scan_step1", 32'(sel_b), 1);
        wait_neg(4);
        check_eq("scan_step2", 32'(sel_b), 2);

        do_load(1234);
        check_eq("busy_after_load", 32'(busy_b), 1);
        wait_neg(20);

        do_load(7);
        wait_neg(20);

        do_load(12000);
        wait_neg(16);
        check_eq("ovf_12000", 32'(ovf_b), 1);
        do_load(0);
        wait_neg(16);
        check_eq("ovf_clear", 32'(ovf_b), 0);
        wait_neg(4);

        // load during busy is dropped
        do_load(4321);
        wait_neg(4);
        i_value = 14'd9999;
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        wait_neg(20);
        check_eq("drop_ovf", 32'(ovf_b), 0);

        // reset mid-conversion
        do_load(5678);
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all_zero("mid_reset");
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(10);
        check_eq("no_valid_after_reset", 32'(en_s), 0);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: i_value = 14'($urandom_range(0, 99));
                    1: i_value = 14'($urandom_range(10000, 16383));
                    default: i_value = 14'($urandom_range(0, 9999));
                endcase
                i_load = 1'b1;
            end else begin
                i_load = 1'b0;
            end
        end
        @(negedge clk);
        i_load = 1'b0;
        wait_neg(20);
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
